// File: rtl/alu_sequencer_if.sv
// Decoder/ALU-side bundle for the relay ALU sequencer.
// master = decoder plus ALU datapath, slave = sequencer.
interface alu_sequencer_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [2:0]       fn;
   logic             dest;
   logic [WIDTH-1:0] b_in;
   logic [WIDTH-1:0] c_in;
   logic             ready;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_c;
   logic [2:0]       alu_fn;
   logic             alu_enable;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;
   logic [WIDTH-1:0] result;
   logic             a_load;
   logic             d_load;
   logic             flag_zero;
   logic             flag_carry;
   logic             flag_sign;
   logic             done;

   modport master (
      output start, fn, dest, b_in, c_in,
      output alu_result, alu_carry,
      input  ready, alu_b, alu_c, alu_fn, alu_enable,
      input  result, a_load, d_load,
      input  flag_zero, flag_carry, flag_sign, done
   );

   modport slave (
      input  start, fn, dest, b_in, c_in,
      input  alu_result, alu_carry,
      output ready, alu_b, alu_c, alu_fn, alu_enable,
      output result, a_load, d_load,
      output flag_zero, flag_carry, flag_sign, done
   );
endinterface

// File: rtl/alu_sequencer.sv
// Runs one relay-ALU operation per decoder request:
// latch operands, hold for the settle interval, capture, strobe load.
module alu_sequencer #(
   parameter int SETTLE_CYCLES = 4,
   parameter int WIDTH         = 8
) (
   input logic           clock,
   input logic           reset_n,
   alu_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

   state_t           state;
   state_t           state_nx;
   logic [3:0]       cnt;
   logic             accept;
   logic             capture;
   logic             dest_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] c_q;
   logic [2:0]       fn_q;
   logic [WIDTH-1:0] res_q;
   logic             zf_q;
   logic             cf_q;
   logic             sf_q;

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      capture  = 1'b0;
      unique case (1'b1)
         (state == IDLE): begin
            if (bus.start) begin
               accept   = 1'b1;
               state_nx = SETTLE;
            end
         end
         (state == SETTLE): begin
            if (cnt == 4'd0) begin
               capture  = 1'b1;
               state_nx = DONE;
            end
         end
         (state == DONE): state_nx = IDLE;
         default:         state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= 4'd0;
      end else if (accept) begin
         cnt <= CNT_INIT;
      end else if (state == SETTLE && cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

   // Operands only move on acceptance so the relays see stable inputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         b_q    <= '0;
         c_q    <= '0;
         fn_q   <= 3'd0;
         dest_q <= 1'b0;
      end else if (accept) begin
         b_q    <= bus.b_in;
         c_q    <= bus.c_in;
         fn_q   <= bus.fn;
         dest_q <= bus.dest;
      end
   end

   // Carry is only meaningful for ADD (0) and INC (1).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         res_q <= '0;
         zf_q  <= 1'b0;
         cf_q  <= 1'b0;
         sf_q  <= 1'b0;
      end else if (capture) begin
         res_q <= bus.alu_result;
         zf_q  <= (bus.alu_result == '0);
         cf_q  <= (fn_q[2:1] == 2'b00) && bus.alu_carry;
         sf_q  <= bus.alu_result[WIDTH-1];
      end
   end

   assign bus.ready      = (state == IDLE);
   assign bus.alu_enable = (state == SETTLE);
   assign bus.done       = (state == DONE);
   assign bus.a_load     = (state == DONE) && !dest_q;
   assign bus.d_load     = (state == DONE) && dest_q;
   assign bus.alu_b      = b_q;
   assign bus.alu_c      = c_q;
   assign bus.alu_fn     = fn_q;
   assign bus.result     = res_q;
   assign bus.flag_zero  = zf_q;
   assign bus.flag_carry = cf_q;
   assign bus.flag_sign  = sf_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: relay-ALU model, transaction-level
// reference model with per-cycle compare, directed literal checks.
module tb_alu_sequencer;

   logic clock = 1'b0;
   logic reset_n;
   logic force_c = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   ndone = 0;
   int   lat;
   int   n0;

   always #5 clock = ~clock;

   alu_sequencer_if #(.WIDTH(8)) ifc0 ();
   alu_sequencer_if #(.WIDTH(8)) ifc1 ();

   alu_sequencer #(.SETTLE_CYCLES(4), .WIDTH(8)) dut0 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (ifc0)
   );

   alu_sequencer #(.SETTLE_CYCLES(1), .WIDTH(8)) dut1 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (ifc1)
   );

   function automatic logic [8:0] alu_f(logic [2:0] f, logic [7:0] b, logic [7:0] c);
      case (f)
         3'd0:    return {1'b0, b} + {1'b0, c};
         3'd1:    return {1'b0, b} + 9'd1;
         3'd2:    return {1'b0, b & c};
         3'd3:    return {1'b0, b | c};
         3'd4:    return {1'b0, b ^ c};
         3'd5:    return {1'b0, ~b};
         3'd6:    return {b, 1'b0};
         default: return 9'd0;
      endcase
   endfunction

   function automatic logic [7:0] f_res(logic [2:0] f, logic [7:0] b, logic [7:0] c);
      logic [8:0] r;
      r = alu_f(f, b, c);
      return r[7:0];
   endfunction

   function automatic logic f_cy(logic [2:0] f, logic [7:0] b, logic [7:0] c);
      logic [8:0] r;
      r = alu_f(f, b, c);
      return r[8];
   endfunction

   // External relay ALU: purely combinational from the registered operands
   always_comb begin
      {ifc0.alu_carry, ifc0.alu_result} = alu_f(ifc0.alu_fn, ifc0.alu_b, ifc0.alu_c);
      if (force_c) ifc0.alu_carry = 1'b1;
   end

   always_comb begin
      {ifc1.alu_carry, ifc1.alu_result} = alu_f(ifc1.alu_fn, ifc1.alu_b, ifc1.alu_c);
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model for dut0 (4 settle cycles): transaction view
   int         ecnt;
   int         k;
   bit         busy;
   logic [7:0] mb, mc, mres;
   logic [2:0] mfn;
   logic       mdest, mz, mcf, ms;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ecnt <= 0;
         k <= 0;
         busy <= 1'b0;
         mb <= 8'h00;
         mc <= 8'h00;
         mfn <= 3'd0;
         mdest <= 1'b0;
         mres <= 8'h00;
         mz <= 1'b0;
         mcf <= 1'b0;
         ms <= 1'b0;
      end else begin
         ecnt <= ecnt + 1;
         if (busy && ecnt - k == 4) begin
            mres <= f_res(mfn, mb, mc);
            mz <= (f_res(mfn, mb, mc) == 8'h00);
            ms <= f_res(mfn, mb, mc) >> 7;
            mcf <= (mfn <= 3'd1) ? (f_cy(mfn, mb, mc) | force_c) : 1'b0;
         end
         if (busy && ecnt - k == 5) begin
            busy <= 1'b0;
         end else if (!busy && ifc0.start) begin
            busy <= 1'b1;
            k <= ecnt;
            mb <= ifc0.b_in;
            mc <= ifc0.c_in;
            mfn <= ifc0.fn;
            mdest <= ifc0.dest;
         end
      end
   end

   always @(negedge clock) begin : cmp
      int   ph;
      logic e_en;
      logic e_done;
      if (reset_n) begin
         ph = ecnt - k - 1;
         e_en = busy && ph < 4;
         e_done = busy && ph == 4;
         chk("ready", ifc0.ready, !busy);
         chk("alu_enable", ifc0.alu_enable, e_en);
         chk("done", ifc0.done, e_done);
         chk("a_load", ifc0.a_load, e_done && !mdest);
         chk("d_load", ifc0.d_load, e_done && mdest);
         chk("alu_b", ifc0.alu_b, mb);
         chk("alu_c", ifc0.alu_c, mc);
         chk("alu_fn", ifc0.alu_fn, mfn);
         chk("result", ifc0.result, mres);
         chk("flag_zero", ifc0.flag_zero, mz);
         chk("flag_carry", ifc0.flag_carry, mcf);
         chk("flag_sign", ifc0.flag_sign, ms);
         if (ifc0.done) ndone++;
      end
   end

   // Issue one op on dut0 from a negedge in IDLE, then scramble inputs.
   task automatic op0(logic [2:0] f, logic d, logic [7:0] b, logic [7:0] c, output int l);
      ifc0.fn = f;
      ifc0.dest = d;
      ifc0.b_in = b;
      ifc0.c_in = c;
      ifc0.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      ifc0.start = 1'b0;
      ifc0.b_in = ~b;
      ifc0.c_in = ~c;
      ifc0.fn = ~f;
      ifc0.dest = ~d;
      l = 0;
      while (!ifc0.done && l < 20) begin
         @(negedge clock);
         l++;
      end
   endtask

   initial begin
      reset_n = 1'b0;
      ifc0.start = 1'b0;
      ifc0.fn = 3'd0;
      ifc0.dest = 1'b0;
      ifc0.b_in = 8'h00;
      ifc0.c_in = 8'h00;
      ifc1.start = 1'b0;
      ifc1.fn = 3'd0;
      ifc1.dest = 1'b0;
      ifc1.b_in = 8'h00;
      ifc1.c_in = 8'h00;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      chk("rst ready", ifc0.ready, 1);
      chk("rst enable", ifc0.alu_enable, 0);
      chk("rst result", ifc0.result, 8'h00);
      chk("rst done", ifc0.done, 0);
      chk("rst ready1", ifc1.ready, 1);

      op0(3'd0, 1'b0, 8'h00, 8'h01, lat);
      chk("add1 latency", lat, 4);
      chk("add1 result", ifc0.result, 8'h01);
      chk("add1 zero", ifc0.flag_zero, 0);
      chk("add1 carry", ifc0.flag_carry, 0);
      chk("add1 sign", ifc0.flag_sign, 0);
      chk("add1 a_load", ifc0.a_load, 1);
      chk("add1 d_load", ifc0.d_load, 0);
      @(negedge clock);

      op0(3'd0, 1'b1, 8'hFF, 8'h01, lat);
      chk("add2 latency", lat, 4);
      chk("add2 result", ifc0.result, 8'h00);
      chk("add2 zero", ifc0.flag_zero, 1);
      chk("add2 carry", ifc0.flag_carry, 1);
      chk("add2 sign", ifc0.flag_sign, 0);
      chk("add2 d_load", ifc0.d_load, 1);
      chk("add2 a_load", ifc0.a_load, 0);
      @(negedge clock);
      chk("add2 d_load width", ifc0.d_load, 0);
      chk("add2 ready back", ifc0.ready, 1);

      force_c = 1'b1;
      op0(3'd2, 1'b0, 8'hF0, 8'h90, lat);
      chk("and result", ifc0.result, 8'h90);
      chk("and sign", ifc0.flag_sign, 1);
      chk("and carry", ifc0.flag_carry, 0);
      @(negedge clock);
      force_c = 1'b0;

      op0(3'd5, 1'b0, 8'h0F, 8'h33, lat);
      chk("not result", ifc0.result, 8'hF0);
      @(negedge clock);
      op0(3'd6, 1'b1, 8'h81, 8'h00, lat);
      chk("shl result", ifc0.result, 8'h02);
      chk("shl carry", ifc0.flag_carry, 0);
      @(negedge clock);
      op0(3'd7, 1'b0, 8'hAA, 8'h55, lat);
      chk("clr zero", ifc0.flag_zero, 1);
      @(negedge clock);

      // start held high: accepts at relative edges 0, 6, 12, 18
      n0 = ndone;
      ifc0.start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         ifc0.b_in = 8'($urandom);
         ifc0.c_in = 8'($urandom);
         ifc0.fn = 3'(i);
         ifc0.dest = i[0];
         @(negedge clock);
      end
      ifc0.start = 1'b0;
      repeat (10) @(negedge clock);
      chk("held start dones", ndone - n0, 4);

      op0(3'd3, 1'b0, 8'h80, 8'h01, lat);
      chk("or result", ifc0.result, 8'h81);
      @(negedge clock);

      // Abort in the 2nd settle cycle
      ifc0.fn = 3'd0;
      ifc0.dest = 1'b1;
      ifc0.b_in = 8'h12;
      ifc0.c_in = 8'h34;
      ifc0.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      ifc0.start = 1'b0;
      @(posedge clock);
      #2;
      n0 = ndone;
      reset_n = 1'b0;
      #1;
      chk("abort ready", ifc0.ready, 1);
      chk("abort enable", ifc0.alu_enable, 0);
      chk("abort result", ifc0.result, 8'h00);
      chk("abort sign", ifc0.flag_sign, 0);
      chk("abort done", ifc0.done, 0);
      chk("abort d_load", ifc0.d_load, 0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (8) @(negedge clock);
      chk("abort no done", ndone - n0, 0);

      op0(3'd1, 1'b1, 8'h10, 8'h00, lat);
      chk("post abort latency", lat, 4);
      chk("post abort result", ifc0.result, 8'h11);
      chk("post abort d_load", ifc0.d_load, 1);
      @(negedge clock);

      // One-cycle settle instance
      ifc1.fn = 3'd1;
      ifc1.dest = 1'b0;
      ifc1.b_in = 8'h7F;
      ifc1.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      ifc1.start = 1'b0;
      ifc1.b_in = 8'h00;
      lat = 0;
      while (!ifc1.done && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      chk("s1 latency", lat, 1);
      chk("s1 result", ifc1.result, 8'h80);
      chk("s1 sign", ifc1.flag_sign, 1);
      chk("s1 carry", ifc1.flag_carry, 0);
      chk("s1 a_load", ifc1.a_load, 1);
      @(negedge clock);
      chk("s1 ready back", ifc1.ready, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
